// File: rtl/ems_page_controller_pkg.sv
// Shared definitions for the EMS page-mapping controller: frame codes,
// I/O port stride and the write-path state encoding.
package ems_pkg;

  localparam logic [1:0] FRAME_C000 = 2'b00;
  localparam logic [1:0] FRAME_D000 = 2'b01;
  localparam logic [1:0] FRAME_E000 = 2'b10;
  localparam logic [1:0] FRAME_OFF  = 2'b11;

  localparam logic [15:0] IO_STRIDE = 16'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WR_ACTIVE = 2'b01,
    COMMIT    = 2'b10
  } wr_state_t;

endpackage

// File: rtl/ems_page_controller.sv
// EMS page controller: four 7-bit page registers behind a 4-port I/O window,
// plus the 64 KB frame decode that steers the RAM block.
//
// state     | meaning
// IDLE      | no EMS port write in progress
// WR_ACTIVE | write strobe low on an EMS port; index/data being captured
// COMMIT    | strobe has risen; captured data written to the page register
module ems_page_controller
  import ems_pkg::*;
#(
  parameter logic [15:0] IO_BASE_0       = 16'h0260,
  parameter logic [6:0]  RESET_PAGE_BASE = 7'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [7:0]  internal_data_bus,
  input  logic        io_read_n,
  input  logic        io_write_n,
  input  logic        memory_read_n,
  input  logic        memory_write_n,
  input  logic        ems_enable,
  input  logic [1:0]  ems_io_sel,
  input  logic [1:0]  ems_frame_sel,
  output logic [6:0]  map_ems [0:3],
  output logic        ems_b1,
  output logic        ems_b2,
  output logic        ems_b3,
  output logic        ems_b4,
  output logic        ems_io_select_n,
  output logic [7:0]  data_bus_out
);

  wr_state_t   state, state_next;
  logic        active_enable;
  logic [1:0]  active_frame;
  logic [15:0] io_base;
  logic        io_hit;
  logic        io_read_hit;
  logic        wr_start;
  logic        capture;
  logic        commit;
  logic        bus_idle;
  logic        frame_hit;
  logic [1:0]  wr_idx;
  logic [6:0]  wr_data;
  logic        unused_data_msb;

  assign unused_data_msb = internal_data_bus[7];

  assign io_base     = IO_BASE_0 + IO_STRIDE * {14'd0, ems_io_sel};
  assign io_hit      = (address[15:2] == io_base[15:2]);
  assign io_read_hit = io_hit & ~io_read_n & active_enable;
  assign wr_start    = io_hit & ~io_write_n & active_enable;
  assign bus_idle    = memory_read_n & memory_write_n & io_read_n & io_write_n;

  assign ems_io_select_n = ~io_read_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (wr_start) state_next = WR_ACTIVE;
      WR_ACTIVE: if (io_write_n) state_next = COMMIT;
      COMMIT:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Capture only while the port is addressed, so a strobe that wanders off
  // the window keeps the last valid index.
  always_comb begin
    capture = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE:      capture = wr_start;
      WR_ACTIVE: capture = io_hit & ~io_write_n;
      COMMIT:    commit  = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_idx  <= 2'd0;
      wr_data <= 7'd0;
    end else if (capture) begin
      wr_idx  <= address[1:0];
      wr_data <= internal_data_bus[6:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) map_ems[i] <= RESET_PAGE_BASE + 7'(i);
    end else if (commit) begin
      map_ems[wr_idx] <= wr_data;
    end
  end

  // Registered readback; a same-cycle commit is seen one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            data_bus_out <= 8'd0;
    else if (io_read_hit) data_bus_out <= {1'b0, map_ems[address[1:0]]};
    else                  data_bus_out <= 8'd0;
  end

  // Configuration only moves between bus cycles so the frame is stable under an access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_enable <= 1'b0;
      active_frame  <= FRAME_OFF;
    end else if (bus_idle) begin
      active_enable <= ems_enable;
      active_frame  <= ems_frame_sel;
    end
  end

  assign frame_hit = active_enable & (active_frame != FRAME_OFF) &
                     (address[19:16] == {2'b11, active_frame});

  assign ems_b1 = frame_hit & (address[15:14] == 2'd0);
  assign ems_b2 = frame_hit & (address[15:14] == 2'd1);
  assign ems_b3 = frame_hit & (address[15:14] == 2'd2);
  assign ems_b4 = frame_hit & (address[15:14] == 2'd3);

endmodule
